// File: rtl/hamming74_tx_serializer_if.sv
// Byte-in / bit-out bundle for the Hamming(7,4) transmit serializer.
// Handshakes: a byte moves when in_valid && in_ready at a rising clk edge, and a serial bit
// moves when tx_valid && tx_ready at a rising edge. A producer holds its payload stable while
// its valid is high and not yet accepted.
interface hamming74_tx_serializer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] inject_pos;
  logic       tx_bit;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_first;
  logic       tx_last;

  modport slave (
    input  in_data, in_valid, inject_pos, tx_ready,
    output in_ready, tx_bit, tx_valid, tx_first, tx_last
  );

  modport master (
    output in_data, in_valid, inject_pos, tx_ready,
    input  in_ready, tx_bit, tx_valid, tx_first, tx_last
  );
endinterface

// File: rtl/hamming74_tx_serializer.sv
// Accepts a byte, encodes each nibble as a Hamming(7,4) codeword [p1 p2 d0 p3 d1 d2 d3]
// and shifts both codewords out LSB-first, low nibble first, with optional bit-flip injection.
module hamming74_tx_serializer #(
  parameter bit INJECT_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  hamming74_tx_serializer_if.slave bus,
  output logic [1:0]               state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [2:0] bit_idx;
  logic [2:0] bit_idx_next;
  logic [6:0] cw_lo;
  logic [6:0] cw_hi;
  logic [6:0] mask;
  logic       accept;

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic p1;
    logic p2;
    logic p3;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p3 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p3, d[0], p2, p1};
  endfunction

  // The same injected position is flipped in both codewords of the byte.
  always_comb begin
    mask = '0;
    if (INJECT_EN && (bus.inject_pos != 3'd0)) begin
      mask = 7'd1 << (bus.inject_pos - 3'd1);
    end
  end

  assign accept = (state == IDLE) && bus.in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_idx <= '0;
      cw_lo   <= '0;
      cw_hi   <= '0;
    end else begin
      state   <= state_next;
      bit_idx <= bit_idx_next;
      if (accept) begin
        cw_lo <= encode(bus.in_data[3:0]) ^ mask;
        cw_hi <= encode(bus.in_data[7:4]) ^ mask;
      end
    end
  end

  always_comb begin
    state_next   = state;
    bit_idx_next = bit_idx;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          state_next   = SEND_LO;
          bit_idx_next = '0;
        end
      end
      SEND_LO: begin
        if (bus.tx_ready) begin
          if (bit_idx == 3'd6) begin
            state_next   = SEND_HI;
            bit_idx_next = '0;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end
      end
      SEND_HI: begin
        if (bus.tx_ready) begin
          if (bit_idx == 3'd6) begin
            state_next   = IDLE;
            bit_idx_next = '0;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end
      end
      default: begin
        state_next   = IDLE;
        bit_idx_next = '0;
      end
    endcase
  end

  // Outputs decode registered state only; in_ready is also held low during reset.
  always_comb begin
    bus.in_ready = (state == IDLE) && !rst;
    bus.tx_valid = (state != IDLE);
    bus.tx_bit   = 1'b0;
    case (state)
      SEND_LO: bus.tx_bit = cw_lo[bit_idx];
      SEND_HI: bus.tx_bit = cw_hi[bit_idx];
      default: bus.tx_bit = 1'b0;
    endcase
    bus.tx_first = (state != IDLE) && (bit_idx == 3'd0);
    bus.tx_last  = (state == SEND_HI) && (bit_idx == 3'd6);
    state_dbg    = state;
  end

endmodule

// File: tb/tb_hamming74_tx_serializer.sv
// Bench for hamming74_tx_serializer: a positional Hamming(7,4) reference builds the expected
// bit stream per accepted byte; an injecting and a non-injecting instance run in lockstep.
module tb_hamming74_tx_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hamming74_tx_serializer_if bus0();
  hamming74_tx_serializer_if bus1();
  logic [1:0] state_dbg0;
  logic [1:0] state_dbg1;

  hamming74_tx_serializer #(.INJECT_EN(1'b1)) dut_inj (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus0),
    .state_dbg (state_dbg0)
  );

  hamming74_tx_serializer #(.INJECT_EN(1'b0)) dut_noinj (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus1),
    .state_dbg (state_dbg1)
  );

  assign bus1.in_data    = bus0.in_data;
  assign bus1.in_valid   = bus0.in_valid;
  assign bus1.inject_pos = bus0.inject_pos;
  assign bus1.tx_ready   = bus0.tx_ready;

  int n_checks = 0;
  int n_pass   = 0;
  int frames_done = 0;
  int xfer_cnt = 0;
  bit stall_mode = 1'b0;

  // Entry: {bit without injection, last, first, bit with injection}
  logic [3:0]  exp_q[$];
  logic [10:0] src_q[$];
  logic [13:0] frame_bits  = '0;
  logic [13:0] frame_bits1 = '0;
  logic [13:0] last_frame  = '0;
  logic [13:0] last_frame1 = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Positions 1..7 hold the codeword; parity at 1,2,4 covers every data position sharing that bit.
  function automatic logic [6:0] ref_encode(input logic [3:0] nib);
    logic [7:1] p;
    int k;
    p    = '0;
    p[3] = nib[0];
    p[5] = nib[1];
    p[6] = nib[2];
    p[7] = nib[3];
    for (int b = 0; b < 3; b++) begin
      k = 1 << b;
      for (int j = 3; j <= 7; j++) begin
        if (j != 4 && (j & k) != 0) p[k] = p[k] ^ p[j];
      end
    end
    return p[7:1];
  endfunction

  task automatic push_frame(input logic [10:0] item);
    logic [6:0] cw[2];
    logic [6:0] cwi[2];
    int pos;
    pos    = int'(item[10:8]);
    cw[0]  = ref_encode(item[3:0]);
    cw[1]  = ref_encode(item[7:4]);
    for (int h = 0; h < 2; h++) begin
      cwi[h] = cw[h];
      if (pos != 0) cwi[h][pos-1] = ~cwi[h][pos-1];
      for (int i = 0; i < 7; i++)
        exp_q.push_back({cw[h][i], (h == 1 && i == 6), (i == 0), cwi[h][i]});
    end
  endtask

  task automatic step();
    logic [3:0] head;
    @(posedge clk);
    #1;
    check("tx_valid", bus0.tx_valid, exp_q.size() != 0);
    check("in_ready", bus0.in_ready, exp_q.size() == 0);
    check("tx_valid_noinj", bus1.tx_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      check("tx_bit", bus0.tx_bit, head[0]);
      check("tx_first", bus0.tx_first, head[1]);
      check("tx_last", bus0.tx_last, head[2]);
      check("tx_bit_noinj", bus1.tx_bit, head[3]);
    end else begin
      check("idle_tx_bit", bus0.tx_bit, 0);
      check("idle_tx_first", bus0.tx_first, 0);
      check("idle_tx_last", bus0.tx_last, 0);
    end
    bus0.tx_ready = stall_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    if (src_q.size() != 0) begin
      bus0.in_valid   = 1'b1;
      bus0.in_data    = src_q[0][7:0];
      bus0.inject_pos = src_q[0][10:8];
    end else begin
      bus0.in_valid   = 1'b0;
      bus0.in_data    = 8'($urandom);
      bus0.inject_pos = 3'($urandom);
    end
    if (exp_q.size() != 0) begin
      if (bus0.tx_ready) begin
        head = exp_q.pop_front();
        frame_bits[xfer_cnt]  = bus0.tx_bit;
        frame_bits1[xfer_cnt] = bus1.tx_bit;
        xfer_cnt++;
        if (head[2]) begin
          last_frame  = frame_bits;
          last_frame1 = frame_bits1;
          xfer_cnt    = 0;
          frames_done++;
        end
      end
    end else if (bus0.in_valid) begin
      push_frame(src_q.pop_front());
    end
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || src_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    step();
  endtask

  initial begin
    int start;
    int n;
    rst             = 1'b1;
    bus0.in_valid   = 1'b0;
    bus0.in_data    = '0;
    bus0.inject_pos = '0;
    bus0.tx_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus0.in_ready, 0);
    check("rst_tx_valid", bus0.tx_valid, 0);
    check("rst_tx_bit", bus0.tx_bit, 0);
    check("rst_tx_first", bus0.tx_first, 0);
    check("rst_tx_last", bus0.tx_last, 0);
    rst = 1'b0;
    step();

    src_q.push_back({3'd0, 8'h0B});
    run_until_idle(100);
    check("frame_0x0b", last_frame, 14'h0055);

    src_q.push_back({3'd0, 8'hF0});
    run_until_idle(100);
    check("frame_0xf0", last_frame, 14'h3F80);

    src_q.push_back({3'd3, 8'h00});
    run_until_idle(100);
    check("frame_inject3", last_frame, 14'h0204);
    check("frame_inject3_disabled", last_frame1, 14'h0000);

    start = frames_done;
    src_q.push_back({3'd0, 8'h0B});
    src_q.push_back({3'd0, 8'hF0});
    run_until_idle(200);
    check("b2b_frames", frames_done - start, 2);
    check("b2b_last_frame", last_frame, 14'h3F80);

    stall_mode = 1'b1;
    start = frames_done;
    for (int b = 0; b < 256; b++)
      src_q.push_back({3'($urandom_range(0, 7)), 8'(b)});
    run_until_idle(30000);
    check("all_bytes_frames", frames_done - start, 256);
    stall_mode = 1'b0;

    // Abort a frame with reset just as its fifth bit is presented.
    src_q.push_back({3'd0, 8'hA5});
    n = 0;
    while (!(exp_q.size() != 0 && xfer_cnt == 4) && n < 50) begin
      step();
      n++;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_tx_valid", bus0.tx_valid, 0);
    check("abort_in_ready", bus0.in_ready, 0);
    check("abort_tx_bit", bus0.tx_bit, 0);
    check("abort_tx_first", bus0.tx_first, 0);
    check("abort_tx_last", bus0.tx_last, 0);
    check("abort_tx_valid_noinj", bus1.tx_valid, 0);
    exp_q.delete();
    xfer_cnt    = 0;
    frame_bits  = '0;
    frame_bits1 = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    src_q.push_back({3'd0, 8'h0B});
    run_until_idle(100);
    check("frame_after_reset", last_frame, 14'h0055);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
